// File: rtl/xbuf_fill.sv
`default_nettype none
// ============================================================================
// Module      : xbuf_fill
// Description : Instruction-stream byte buffer feeding XBUF<15:0> to the IRD
//               gate array and IRD ROMs. Aligned longwords from the memory
//               interface are appended to a byte FIFO; the two head bytes are
//               presented on xbuf_h (byte 0 in [7:0]). The decoder retires
//               0-4 bytes per cycle and is stalled when it asks for more bytes
//               than are held.
// Ports       : buf_m_clk_l  - M clock, rising-edge state updates
//               init_l       - asynchronous active-low reset
//               flush_h      - discard contents, restart at new PC
//               new_pc_h     - PC<1:0> of restart address (sampled with flush)
//               mem_rdy_h    - memory longword valid
//               mem_data_h   - longword, byte 0 in [7:0]
//               ib_req_h     - request next sequential longword
//               cons_h       - decoder retires bytes this cycle
//               cons_cnt_h   - bytes retired (5-7 treated as 4)
//               xbuf_h       - next two I-stream bytes (registered)
//               xbuf_vld_h   - per-byte valid for xbuf_h lanes (registered)
//               ib_cnt_h     - valid bytes held
//               ib_stall_h   - consume request exceeds bytes held
//               stall_cnt_h  - saturating stall-cycle counter (optional)
// Options     : XBUF_STALL_CNT_EN - when defined, adds stall_cnt_h[15:0]
// Revision    : 1.0 - initial release
// ============================================================================
module xbuf_fill #(
    parameter int IB_BYTES = 8,
    parameter int CNT_W    = 4
) (
    input  logic             buf_m_clk_l,
    input  logic             init_l,
    input  logic             flush_h,
    input  logic [1:0]       new_pc_h,
    input  logic             mem_rdy_h,
    input  logic [31:0]      mem_data_h,
    output logic             ib_req_h,
    input  logic             cons_h,
    input  logic [2:0]       cons_cnt_h,
    output logic [15:0]      xbuf_h,
    output logic [1:0]       xbuf_vld_h,
    output logic [CNT_W-1:0] ib_cnt_h,
`ifdef XBUF_STALL_CNT_EN
    output logic [15:0]      stall_cnt_h,
`endif
    output logic             ib_stall_h
);

    localparam int c_idx_w = $clog2(IB_BYTES);

    logic [7:0]       slot_q [IB_BYTES];
    logic [7:0]       slot_d [IB_BYTES];
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       skip_q, skip_d;
    logic             ib_req_q, ib_req_d;
    logic [15:0]      xbuf_q, xbuf_d;
    logic [1:0]       vld_q, vld_d;
    logic [7:0]       lw_byte [4];
    logic             stall;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lw_byte[k] = mem_data_h[8*k +: 8];
        end
    end

    always_comb begin
        int  cnt_i, sat_i, retire_i, rem_i, app_i, skip_i, src_i;
        logic fill;
        cnt_i    = int'(count_q);
        skip_i   = int'(skip_q);
        sat_i    = (cons_cnt_h > 3'd4) ? 4 : int'(cons_cnt_h);
        // Flush overrides everything, including the stall indication.
        stall    = cons_h & ~flush_h & (sat_i > cnt_i);
        retire_i = (cons_h && !flush_h && !stall) ? sat_i : 0;
        fill     = ib_req_q & mem_rdy_h & ~flush_h;
        rem_i    = cnt_i - retire_i;
        // After a flush the first longword drops the bytes below the restart PC.
        app_i    = fill ? (4 - skip_i) : 0;

        for (int i = 0; i < IB_BYTES; i++) begin
            slot_d[i] = slot_q[i];
            src_i     = i + retire_i;
            if (!flush_h) begin
                if (src_i < cnt_i) begin
                    slot_d[i] = slot_q[c_idx_w'(src_i)];
                end else if (i >= rem_i && i < rem_i + app_i) begin
                    slot_d[i] = lw_byte[2'(i - rem_i + skip_i)];
                end
            end
        end

        count_d = flush_h ? '0 : CNT_W'(rem_i + app_i);
        skip_d  = flush_h ? new_pc_h : (fill ? 2'b00 : skip_q);

        // Request only when a whole longword is guaranteed to fit.
        ib_req_d = (IB_BYTES - int'(count_d)) >= 4;

        vld_d[0] = (int'(count_d) >= 1);
        vld_d[1] = (int'(count_d) >= 2);
        xbuf_d   = {vld_d[1] ? slot_d[1] : 8'h00,
                    vld_d[0] ? slot_d[0] : 8'h00};
    end

    always_ff @(posedge buf_m_clk_l or negedge init_l) begin
        if (!init_l) begin
            for (int i = 0; i < IB_BYTES; i++) begin
                slot_q[i] <= 8'h00;
            end
            count_q  <= '0;
            skip_q   <= 2'b00;
            ib_req_q <= 1'b0;
            xbuf_q   <= 16'h0000;
            vld_q    <= 2'b00;
        end else begin
            for (int i = 0; i < IB_BYTES; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q  <= count_d;
            skip_q   <= skip_d;
            ib_req_q <= ib_req_d;
            xbuf_q   <= xbuf_d;
            vld_q    <= vld_d;
        end
    end

    assign ib_req_h   = ib_req_q;
    assign xbuf_h     = xbuf_q;
    assign xbuf_vld_h = vld_q;
    assign ib_cnt_h   = count_q;
    assign ib_stall_h = stall;

`ifdef XBUF_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge buf_m_clk_l or negedge init_l) begin
        if (!init_l) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_h = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xbuf_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbuf_fill
// Description : Self-checking bench for xbuf_fill: directed vector table,
//               asynchronous reset sequence and randomized traffic checked
//               against a byte-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbuf_fill;

    localparam int IB_BYTES = 8;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             init_l = 1'b0;
    logic             flush_h = 1'b0;
    logic [1:0]       new_pc_h = 2'b00;
    logic             mem_rdy_h = 1'b0;
    logic [31:0]      mem_data_h = 32'h0;
    logic             cons_h = 1'b0;
    logic [2:0]       cons_cnt_h = 3'd0;
    logic             ib_req_h;
    logic [15:0]      xbuf_h;
    logic [1:0]       xbuf_vld_h;
    logic [CNT_W-1:0] ib_cnt_h;
    logic             ib_stall_h;
`ifdef XBUF_STALL_CNT_EN
    logic [15:0]      stall_cnt_h;
`endif

    always #5 clk = ~clk;

    xbuf_fill #(.IB_BYTES(IB_BYTES), .CNT_W(CNT_W)) u_dut (
        .buf_m_clk_l (clk),
        .init_l      (init_l),
        .flush_h     (flush_h),
        .new_pc_h    (new_pc_h),
        .mem_rdy_h   (mem_rdy_h),
        .mem_data_h  (mem_data_h),
        .ib_req_h    (ib_req_h),
        .cons_h      (cons_h),
        .cons_cnt_h  (cons_cnt_h),
        .xbuf_h      (xbuf_h),
        .xbuf_vld_h  (xbuf_vld_h),
        .ib_cnt_h    (ib_cnt_h),
`ifdef XBUF_STALL_CNT_EN
        .stall_cnt_h (stall_cnt_h),
`endif
        .ib_stall_h  (ib_stall_h)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        f;
        bit [1:0]  pc;
        bit        r;
        bit [31:0] d;
        bit        c;
        bit [2:0]  n;
        bit        e_req;
        bit        e_stall;
        int        e_cnt;
        bit [15:0] e_xbuf;
        bit [1:0]  e_vld;
    } vec_t;

    function automatic vec_t mk(bit f, bit [1:0] pc, bit r, bit [31:0] d, bit c, bit [2:0] n,
                                bit e_req, bit e_stall, int e_cnt, bit [15:0] e_xbuf, bit [1:0] e_vld);
        vec_t v;
        v.f = f; v.pc = pc; v.r = r; v.d = d; v.c = c; v.n = n;
        v.e_req = e_req; v.e_stall = e_stall; v.e_cnt = e_cnt; v.e_xbuf = e_xbuf; v.e_vld = e_vld;
        return v;
    endfunction

    // Drive one cycle's inputs shortly after the active edge and settle.
    task automatic apply(input bit f, input bit [1:0] pc, input bit r, input bit [31:0] d,
                         input bit c, input bit [2:0] n);
        flush_h = f; new_pc_h = pc; mem_rdy_h = r; mem_data_h = d;
        cons_h = c; cons_cnt_h = n;
        #2;
    endtask

    // Reference model: byte queue, pending skip, registered request.
    logic [7:0] mq[$];
    int         mskip;
    bit         mreq;
    int         mstall_cnt;

    task automatic do_reset();
        @(posedge clk);
        #3;
        init_l = 1'b0;
        #1;
        chk("rst_cnt",   32'(ib_cnt_h),   0);
        chk("rst_xbuf",  32'(xbuf_h),     0);
        chk("rst_vld",   32'(xbuf_vld_h), 0);
        chk("rst_req",   32'(ib_req_h),   0);
`ifdef XBUF_STALL_CNT_EN
        chk("rst_stcnt", 32'(stall_cnt_h), 0);
`endif
        flush_h = 0; new_pc_h = 0; mem_rdy_h = 0; mem_data_h = 0; cons_h = 0; cons_cnt_h = 0;
        @(posedge clk);
        #3;
        init_l = 1'b1;
        mq.delete();
        mskip = 0;
        mreq = 0;
        mstall_cnt = 0;
    endtask

    initial begin
        vec_t tbl[$];
        int   exp_stcnt;

        // f pc r data c n | req stall cnt xbuf vld
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 16'h0000, 2'b00));
        tbl.push_back(mk(0, 0, 1, 32'h44332211, 0, 0, 1, 0, 4, 16'h2211, 2'b11));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 3, 1, 0, 1, 16'h0044, 2'b01));
        tbl.push_back(mk(1, 3, 0, 32'h0,        0, 0, 1, 0, 0, 16'h0000, 2'b00));
        tbl.push_back(mk(0, 0, 1, 32'hDDCCBBAA, 0, 0, 1, 0, 1, 16'h00DD, 2'b01));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 2, 1, 1, 1, 16'h00DD, 2'b01));
        tbl.push_back(mk(0, 0, 1, 32'h44332211, 1, 1, 1, 0, 4, 16'h2211, 2'b11));
        tbl.push_back(mk(0, 0, 1, 32'h88776655, 1, 2, 1, 0, 6, 16'h4433, 2'b11));
        tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 6, 16'h4433, 2'b11));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 7, 0, 0, 2, 16'h8877, 2'b11));
        tbl.push_back(mk(1, 0, 1, 32'hCAFEF00D, 1, 1, 1, 0, 0, 16'h0000, 2'b00));
        tbl.push_back(mk(0, 0, 1, 32'hA1B2C3D4, 0, 0, 1, 0, 4, 16'hC3D4, 2'b11));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0, 1, 0, 0, 16'h0000, 2'b00));
        tbl.push_back(mk(1, 2, 0, 32'h0,        0, 0, 1, 0, 0, 16'h0000, 2'b00));
        tbl.push_back(mk(0, 0, 1, 32'h04030201, 0, 0, 1, 0, 2, 16'h0403, 2'b11));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 0, 1, 0, 2, 16'h0403, 2'b11));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 4, 1, 0, 2, 16'h0403, 2'b11));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 4, 1, 0, 0, 16'h0000, 2'b00));
        tbl.push_back(mk(0, 0, 1, 32'h12345678, 0, 0, 1, 0, 4, 16'h5678, 2'b11));

        do_reset();
        exp_stcnt = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].f, tbl[i].pc, tbl[i].r, tbl[i].d, tbl[i].c, tbl[i].n);
            chk($sformatf("v%0d_req", i),   32'(ib_req_h),   32'(tbl[i].e_req));
            chk($sformatf("v%0d_stall", i), 32'(ib_stall_h), 32'(tbl[i].e_stall));
            if (tbl[i].e_stall) exp_stcnt++;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", i),  32'(ib_cnt_h),   32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_xbuf", i), 32'(xbuf_h),     32'(tbl[i].e_xbuf));
            chk($sformatf("v%0d_vld", i),  32'(xbuf_vld_h), 32'(tbl[i].e_vld));
`ifdef XBUF_STALL_CNT_EN
            chk($sformatf("v%0d_stcnt", i), 32'(stall_cnt_h), 32'(exp_stcnt));
`endif
        end

        // Asynchronous reset while the buffer holds data, then random traffic.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit        f, r, c, st;
            bit [1:0]  pc;
            bit [2:0]  n;
            bit [31:0] d;
            int        sat;
            logic [15:0] ex;
            f  = ($urandom_range(0, 15) == 0);
            pc = 2'($urandom_range(0, 3));
            r  = ($urandom_range(0, 2) != 0);
            c  = ($urandom_range(0, 1) == 1);
            n  = 3'($urandom_range(0, 7));
            d  = $urandom;
            apply(f, pc, r, d, c, n);
            sat = (n > 4) ? 4 : int'(n);
            st  = c && !f && (sat > mq.size());
            chk("rnd_req",   32'(ib_req_h),   32'(mreq));
            chk("rnd_stall", 32'(ib_stall_h), 32'(st));
            @(posedge clk);
            #1;
            if (st && mstall_cnt < 16'hFFFF) mstall_cnt++;
            if (f) begin
                mq.delete();
                mskip = int'(pc);
            end else begin
                if (c && !st) begin
                    repeat (sat) void'(mq.pop_front());
                end
                if (mreq && r) begin
                    for (int k = mskip; k < 4; k++) mq.push_back(d[8*k +: 8]);
                    mskip = 0;
                end
            end
            mreq = (IB_BYTES - mq.size()) >= 4;
            ex[7:0]  = (mq.size() > 0) ? mq[0] : 8'h00;
            ex[15:8] = (mq.size() > 1) ? mq[1] : 8'h00;
            chk("rnd_cnt",  32'(ib_cnt_h),   32'(mq.size()));
            chk("rnd_xbuf", 32'(xbuf_h),     32'(ex));
            chk("rnd_vld",  32'(xbuf_vld_h), {30'd0, mq.size() > 1, mq.size() > 0});
`ifdef XBUF_STALL_CNT_EN
            chk("rnd_stcnt", 32'(stall_cnt_h), 32'(mstall_cnt));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
